id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports clk and reset; one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state.
REQ-004 hold  input  1  E stage frozen (MDU busy); keep all contents.
REQ-005 clr  input  1  insert bubble into E (load-use / Tuse>Tnew stall from hazard unit).
REQ-006 D_instr  input  32  decoded instruction word.
REQ-007 D_pc  input  32  instruction address.
REQ-008 D_bd  input  1  instruction sits in a branch delay slot.
REQ-009 D_rs_data, D_rt_data  input  32 each  forwarded GRF read values.
REQ-010 D_ext  input  32  immediate from the extender (zero/sign/shifted/upper/shamt already applied).
REQ-011 D_tnew  input  2  cycles, counted at D, until the instruction's result is available.
REQ-012 E_instr, E_pc, E_rs_data, E_rt_data, E_ext  output  32 each  registered copies.
REQ-013 E_bd  output  1;  E_tnew  output  2;  E_valid  output  1 (0 = bubble).

Function
REQ-014 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-015 Priority SHALL be clr > hold > load, evaluated each rising edge.
REQ-016 Load (clr=0, hold=0): every E_* field SHALL take its D_* value; E_valid <= 1; latency exactly one cycle.
REQ-017 E_tnew on load SHALL be D_tnew-1, saturating at 0 (D_tnew=0 -> E_tnew=0).
REQ-018 Hold (clr=0, hold=1): all fields including E_valid and E_tnew SHALL keep their values.
REQ-019 Clr: E_instr, E_rs_data, E_rt_data, E_ext <= 0; E_tnew <= 0; E_valid <= 0.
REQ-020 Clr SHALL still load E_pc <= D_pc and E_bd <= D_bd so EPC/BD reporting stays correct for a bubble.
REQ-021 Clr and hold both high SHALL behave as clr (bubble wins).
REQ-022 A bubble (E_instr=0) SHALL be indistinguishable from sll $0,$0,0 downstream; E_valid exists for counters/debug only.
REQ-023 Back-to-back clr cycles SHALL each insert a fresh bubble; no hidden state carries over.
REQ-024 X on D_* inputs SHALL not propagate when clr or hold is asserted (except E_pc/E_bd under clr).

Reset
REQ-025 reset low SHALL immediately (asynchronously) force E_instr=0, E_rs_data=0, E_rt_data=0, E_ext=0, E_tnew=0, E_valid=0, E_bd=0, E_pc=32'h0000_3000.
REQ-026 Reset release SHALL take effect at the first rising clk after reset goes high; hold/clr ignored while reset low.
REQ-027 Reset asserted mid-hold SHALL discard the held instruction; no restore on release.

Structure
REQ-028 Shared package SHALL hold: PC reset value 32'h0000_3000, NOP word 32'h0, Tnew width 2.
REQ-029 No sub-module SHALL be required; single module, one always block per field group.

Verification
REQ-030 Reset: reset=0 mid-cycle with E_valid=1 -> all outputs at reset values before next edge; E_pc=32'h0000_3000.
REQ-031 Load: D_instr=32'h3C01_1234, D_ext=32'h1234_0000, D_tnew=2 -> next edge E_instr=32'h3C01_1234, E_ext=32'h1234_0000, E_tnew=1, E_valid=1.
REQ-032 Saturation: D_tnew=0 with load -> E_tnew=0.
REQ-033 Hold: load then hold=1 for 3 cycles with D_* changing -> E_* unchanged all 3 cycles.
REQ-034 Clr+hold: clr=1, hold=1, D_pc=32'h0000_3010, D_bd=1 -> E_instr=0, E_valid=0, E_tnew=0, E_pc=32'h0000_3010, E_bd=1.
REQ-035 Back-to-back: clr for 2 cycles then load -> two bubbles, then third edge E_valid=1 with new D_* values.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg_pkg
//  Description : Shared constants and helpers for the ID/EX pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
package id_ex_reg_pkg;

  localparam int          TNEW_W   = 2;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef logic [TNEW_W-1:0] tnew_t;

  // One pipeline stage has elapsed between D and E, so Tnew drops by one.
  function automatic tnew_t tnew_dec(input tnew_t t);
    return (t == '0) ? '0 : tnew_t'(t - tnew_t'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg_if
//  Description : D-side inputs, stall controls and E-side outputs of ID/EX.
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_reg_if;
  import id_ex_reg_pkg::*;

  logic        hold;
  logic        clr;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic        D_bd;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic [31:0] D_ext;
  tnew_t       D_tnew;

  logic [31:0] E_instr;
  logic [31:0] E_pc;
  logic        E_bd;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic [31:0] E_ext;
  tnew_t       E_tnew;
  logic        E_valid;

  modport master (
    output hold, clr, D_instr, D_pc, D_bd, D_rs_data, D_rt_data, D_ext, D_tnew,
    input  E_instr, E_pc, E_bd, E_rs_data, E_rt_data, E_ext, E_tnew, E_valid
  );

  modport slave (
    input  hold, clr, D_instr, D_pc, D_bd, D_rs_data, D_rt_data, D_ext, D_tnew,
    output E_instr, E_pc, E_bd, E_rs_data, E_rt_data, E_ext, E_tnew, E_valid
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register with hold (freeze) and clr (bubble).
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   reset,
  id_ex_reg_if.slave  bus
);

  logic load;
  assign load = !bus.clr && !bus.hold;

  // PC and delay-slot flag follow D even on a bubble so EPC/BD stay correct.
  always_ff @(posedge clk or negedge reset) begin : p_pc_bd
    if (!reset) begin
      bus.E_pc <= PC_RESET;
      bus.E_bd <= 1'b0;
    end else if (bus.clr || !bus.hold) begin
      bus.E_pc <= bus.D_pc;
      bus.E_bd <= bus.D_bd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_payload
    if (!reset) begin
      bus.E_instr   <= NOP_WORD;
      bus.E_rs_data <= '0;
      bus.E_rt_data <= '0;
      bus.E_ext     <= '0;
    end else if (bus.clr) begin
      bus.E_instr   <= NOP_WORD;
      bus.E_rs_data <= '0;
      bus.E_rt_data <= '0;
      bus.E_ext     <= '0;
    end else if (load) begin
      bus.E_instr   <= bus.D_instr;
      bus.E_rs_data <= bus.D_rs_data;
      bus.E_rt_data <= bus.D_rt_data;
      bus.E_ext     <= bus.D_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_status
    if (!reset) begin
      bus.E_tnew  <= '0;
      bus.E_valid <= 1'b0;
    end else if (bus.clr) begin
      bus.E_tnew  <= '0;
      bus.E_valid <= 1'b0;
    end else if (load) begin
      bus.E_tnew  <= tnew_dec(bus.D_tnew);
      bus.E_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_reg
//  Description : Self-checking bench for id_ex_reg with a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic clk;
  logic reset;
  id_ex_reg_if bus ();

  id_ex_reg dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
    logic [1:0]  tnew;
    logic        valid;
  } exp_t;

  localparam exp_t RST_EXP = '{instr: 32'h0, pc: 32'h0000_3000, bd: 1'b0, rs: 32'h0,
                               rt: 32'h0, ext: 32'h0, tnew: 2'd0, valid: 1'b0};

  int   total = 0;
  int   bad   = 0;
  bit   check_en = 1'b0;
  exp_t exp_s = RST_EXP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Next E contents from the stage rules: bubble beats freeze beats load.
  function automatic exp_t next_exp(input exp_t cur);
    exp_t n;
    int   t;
    n = cur;
    if (bus.clr) begin
      n       = RST_EXP;
      n.pc    = bus.D_pc;
      n.bd    = bus.D_bd;
    end else if (!bus.hold) begin
      t       = int'(bus.D_tnew) - 1;
      if (t < 0) t = 0;
      n.instr = bus.D_instr;
      n.pc    = bus.D_pc;
      n.bd    = bus.D_bd;
      n.rs    = bus.D_rs_data;
      n.rt    = bus.D_rt_data;
      n.ext   = bus.D_ext;
      n.tnew  = 2'(t);
      n.valid = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) exp_s <= RST_EXP;
    else        exp_s <= next_exp(exp_s);
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("E_instr",   bus.E_instr,          exp_s.instr);
      chk("E_pc",      bus.E_pc,             exp_s.pc);
      chk("E_bd",      32'(bus.E_bd),        32'(exp_s.bd));
      chk("E_rs_data", bus.E_rs_data,        exp_s.rs);
      chk("E_rt_data", bus.E_rt_data,        exp_s.rt);
      chk("E_ext",     bus.E_ext,            exp_s.ext);
      chk("E_tnew",    32'(bus.E_tnew),      32'(exp_s.tnew));
      chk("E_valid",   32'(bus.E_valid),     32'(exp_s.valid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic c, input logic [31:0] instr,
                       input logic [31:0] pc, input logic bd, input logic [31:0] ext,
                       input logic [1:0] tn);
    bus.hold      = h;
    bus.clr       = c;
    bus.D_instr   = instr;
    bus.D_pc      = pc;
    bus.D_bd      = bd;
    bus.D_rs_data = $urandom;
    bus.D_rt_data = $urandom;
    bus.D_ext     = ext;
    bus.D_tnew    = tn;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " E_instr"}, bus.E_instr, 32'h0);
    chk({tag, " E_rs"},    bus.E_rs_data, 32'h0);
    chk({tag, " E_rt"},    bus.E_rt_data, 32'h0);
    chk({tag, " E_ext"},   bus.E_ext, 32'h0);
    chk({tag, " E_tnew"},  32'(bus.E_tnew), 32'h0);
    chk({tag, " E_valid"}, 32'(bus.E_valid), 32'h0);
    chk({tag, " E_bd"},    32'(bus.E_bd), 32'h0);
    chk({tag, " E_pc"},    bus.E_pc, 32'h0000_3000);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'd0);
    #1 reset = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    // Load with literal expectations
    #1 reset = 1'b1;
    drive(1'b0, 1'b0, 32'h3C01_1234, 32'h0000_3004, 1'b0, 32'h1234_0000, 2'd2);
    cyc();
    chk("load E_instr", bus.E_instr, 32'h3C01_1234);
    chk("load E_ext",   bus.E_ext,   32'h1234_0000);
    chk("load E_tnew",  32'(bus.E_tnew), 32'd1);
    chk("load E_valid", 32'(bus.E_valid), 32'd1);
    chk("load E_pc",    bus.E_pc, 32'h0000_3004);

    // Saturation of Tnew
    drive(1'b0, 1'b0, 32'h0000_0821, 32'h0000_3008, 1'b0, 32'h0, 2'd0);
    cyc();
    chk("sat E_tnew", 32'(bus.E_tnew), 32'd0);
    chk("sat E_instr", bus.E_instr, 32'h0000_0821);

    // Hold for three cycles with D changing
    drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_300C, 1'b1, 32'hCAFE_0000, 2'd3);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, $urandom, $urandom, 1'b0, $urandom, 2'($urandom));
      cyc();
      chk("hold E_instr", bus.E_instr, 32'hDEAD_BEEF);
      chk("hold E_pc",    bus.E_pc, 32'h0000_300C);
      chk("hold E_ext",   bus.E_ext, 32'hCAFE_0000);
      chk("hold E_tnew",  32'(bus.E_tnew), 32'd2);
      chk("hold E_bd",    32'(bus.E_bd), 32'd1);
    end

    // Clear and hold together: bubble wins, PC/BD still load
    drive(1'b1, 1'b1, 32'h1111_1111, 32'h0000_3010, 1'b1, 32'h2222_2222, 2'd3);
    cyc();
    chk("clrhold E_instr", bus.E_instr, 32'h0);
    chk("clrhold E_valid", 32'(bus.E_valid), 32'd0);
    chk("clrhold E_tnew",  32'(bus.E_tnew), 32'd0);
    chk("clrhold E_pc",    bus.E_pc, 32'h0000_3010);
    chk("clrhold E_bd",    32'(bus.E_bd), 32'd1);

    // Back-to-back bubbles then a load
    drive(1'b0, 1'b0, 32'h2401_0005, 32'h0000_3014, 1'b0, 32'h5, 2'd1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h3333_3333, 32'h0000_3018 + 32'(i * 4), 1'b0, 32'h4444, 2'd2);
      cyc();
      chk("b2b E_valid", 32'(bus.E_valid), 32'd0);
      chk("b2b E_instr", bus.E_instr, 32'h0);
      chk("b2b E_pc",    bus.E_pc, 32'h0000_3018 + 32'(i * 4));
    end
    drive(1'b0, 1'b0, 32'h8C22_0010, 32'h0000_3020, 1'b0, 32'h10, 2'd3);
    cyc();
    chk("b2b load E_valid", 32'(bus.E_valid), 32'd1);
    chk("b2b load E_instr", bus.E_instr, 32'h8C22_0010);
    chk("b2b load E_tnew",  32'(bus.E_tnew), 32'd2);

    // Asynchronous reset in the middle of a hold; no restore after release
    drive(1'b1, 1'b0, 32'h5555_5555, 32'h0000_4000, 1'b1, 32'h6666, 2'd1);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("async");
    #1 reset = 1'b1;
    cyc();
    chk("post-rst hold E_valid", 32'(bus.E_valid), 32'd0);
    chk("post-rst hold E_pc",    bus.E_pc, 32'h0000_3000);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic h, c;
      h = ($urandom_range(0, 99) < 20);
      c = ($urandom_range(0, 99) < 20);
      drive(h, c, $urandom, $urandom, 1'($urandom), $urandom, 2'($urandom));
      if ((h || c) && ($urandom_range(0, 3) == 0)) begin
        bus.D_instr   = 'x;
        bus.D_rs_data = 'x;
        bus.D_rt_data = 'x;
        bus.D_ext     = 'x;
        bus.D_tnew    = 'x;
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
      cyc();
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
